// File: rtl/counter_sequencer_if.sv
// Control and status bundle for counter_sequencer.
// The master side issues commands and observes status; the slave side is the sequencer.
interface counter_sequencer_if;
   logic       start;
   logic       hold;
   logic       abort;
   logic       auto_reload;
   logic [2:0] load_val;
   logic [2:0] limit;
   logic [2:0] count;
   logic [1:0] state;
   logic       busy;
   logic       done;
   logic       wrap;

   modport master (
      output start, hold, abort, auto_reload, load_val, limit,
      input  count, state, busy, done, wrap
   );

   modport slave (
      input  start, hold, abort, auto_reload, load_val, limit,
      output count, state, busy, done, wrap
   );
endinterface

// File: rtl/counter_sequencer.sv
// Prescaled 3-bit up-counter sequencer with pause, abort, auto-reload and terminal detection.
// All outputs are registered or decoded from registered state.
module counter_sequencer #(
   parameter int unsigned PRESCALE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   counter_sequencer_if.slave   bus_io
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam logic [3:0] PreMax = 4'(PRESCALE - 1);

   state_e     state_q, state_d;
   logic [2:0] count_q, count_d;
   logic [3:0] pre_q, pre_d;
   logic       done_q, done_d;
   logic       wrap_q, wrap_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= 3'd0;
         pre_q   <= 4'd0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pre_q   <= pre_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pre_d   = pre_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;

      if (bus_io.abort) begin
         state_d = StIdle;
         count_d = 3'd0;
         pre_d   = 4'd0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               // hold is not consulted here: a held start enters RUN and pauses one edge later
               if (bus_io.start) begin
                  state_d = StRun;
                  count_d = bus_io.load_val;
                  pre_d   = 4'd0;
               end
            end
            StRun: begin
               if (bus_io.hold) begin
                  state_d = StPause;
               end else if (pre_q == PreMax) begin
                  pre_d = 4'd0;
                  if (count_q != bus_io.limit) begin
                     count_d = count_q + 3'd1;
                  end else if (bus_io.auto_reload) begin
                     count_d = bus_io.load_val;
                     wrap_d  = 1'b1;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end else begin
                  pre_d = pre_q + 4'd1;
               end
            end
            StPause: begin
               if (!bus_io.hold) begin
                  state_d = StRun;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign bus_io.count = count_q;
   assign bus_io.state = state_q;
   assign bus_io.busy  = (state_q == StRun) || (state_q == StPause);
   assign bus_io.done  = done_q;
   assign bus_io.wrap  = wrap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: two sequencers (PRESCALE 1 and 3) share stimulus; a behavioural model
// predicts each cycle's status into per-DUT queues that a negedge monitor drains.
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic       abort = 1'b0;
   logic       auto_reload = 1'b0;
   logic [2:0] load_val = 3'd0;
   logic [2:0] limit = 3'd0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   counter_sequencer_if if_p1 ();
   counter_sequencer_if if_p3 ();

   assign if_p1.start = start;
   assign if_p1.hold = hold;
   assign if_p1.abort = abort;
   assign if_p1.auto_reload = auto_reload;
   assign if_p1.load_val = load_val;
   assign if_p1.limit = limit;
   assign if_p3.start = start;
   assign if_p3.hold = hold;
   assign if_p3.abort = abort;
   assign if_p3.auto_reload = auto_reload;
   assign if_p3.load_val = load_val;
   assign if_p3.limit = limit;

   counter_sequencer #(.PRESCALE(1)) u_p1 (.clk(clk), .rst_n(rst_n), .bus_io(if_p1));
   counter_sequencer #(.PRESCALE(3)) u_p3 (.clk(clk), .rst_n(rst_n), .bus_io(if_p3));

   // Reference model: mode names follow the published state encoding.
   localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;
   int m_mode  [2];
   int m_cnt   [2];
   int m_phase [2];   // RUN cycles elapsed since the last tick
   bit m_done  [2];
   bit m_wrap  [2];
   int m_pre   [2] = '{1, 3};

   logic [7:0] exp_q1 [$];
   logic [7:0] exp_q3 [$];

   task automatic model_reset(input int k);
      m_mode[k] = MIdle;
      m_cnt[k] = 0;
      m_phase[k] = 0;
      m_done[k] = 1'b0;
      m_wrap[k] = 1'b0;
   endtask

   task automatic model_step(input int k);
      m_done[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (!rst_n || abort) begin
         model_reset(k);
      end else if (m_mode[k] == MIdle || m_mode[k] == MDone) begin
         if (start) begin
            m_mode[k] = MRun;
            m_cnt[k] = int'(load_val);
            m_phase[k] = 0;
         end
      end else if (m_mode[k] == MPause) begin
         if (!hold) m_mode[k] = MRun;
      end else if (hold) begin
         m_mode[k] = MPause;
      end else begin
         m_phase[k] = m_phase[k] + 1;
         if (m_phase[k] == m_pre[k]) begin
            m_phase[k] = 0;
            if (m_cnt[k] != int'(limit)) begin
               m_cnt[k] = (m_cnt[k] + 1) % 8;
            end else if (auto_reload) begin
               m_cnt[k] = int'(load_val);
               m_wrap[k] = 1'b1;
            end else begin
               m_mode[k] = MDone;
               m_done[k] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [7:0] model_pack(input int k);
      logic [1:0] st;
      logic [2:0] ct;
      st = 2'(m_mode[k]);
      ct = 3'(m_cnt[k]);
      return {st, ct, (m_mode[k] == MRun || m_mode[k] == MPause), m_done[k], m_wrap[k]};
   endfunction

   // rst_act: 0 none, 1 assert reset between edges, 2 release reset
   task automatic cycle(input bit s, input bit h, input bit a, input bit r,
                        input logic [2:0] lv, input logic [2:0] lm, input int rst_act);
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
      if (rst_act == 1) begin
         rst_n = 1'b0;
         model_reset(0);
         model_reset(1);
      end else if (rst_act == 2) begin
         rst_n = 1'b1;
      end
      exp_q1.push_back(model_pack(0));
      exp_q3.push_back(model_pack(1));
      start = s;
      hold = h;
      abort = a;
      auto_reload = r;
      load_val = lv;
      limit = lm;
   endtask

   task automatic idle_cycles(input int n, input bit r, input logic [2:0] lv,
                              input logic [2:0] lm);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, r, lv, lm, 0);
   endtask

   // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
   initial begin
      logic [7:0] got, exp;
      forever begin
         @(negedge clk);
         if (exp_q1.size() > 0) begin
            exp = exp_q1.pop_front();
            got = {if_p1.state, if_p1.count, if_p1.busy, if_p1.done, if_p1.wrap};
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL pre1_status t=%0t got st=%0d cnt=%0d busy=%b done=%b wrap=%b exp st=%0d cnt=%0d busy=%b done=%b wrap=%b",
                        $time, got[7:6], got[5:3], got[2], got[1], got[0],
                        exp[7:6], exp[5:3], exp[2], exp[1], exp[0]);
            end
         end
         if (exp_q3.size() > 0) begin
            exp = exp_q3.pop_front();
            got = {if_p3.state, if_p3.count, if_p3.busy, if_p3.done, if_p3.wrap};
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL pre3_status t=%0t got st=%0d cnt=%0d busy=%b done=%b wrap=%b exp st=%0d cnt=%0d busy=%b done=%b wrap=%b",
                        $time, got[7:6], got[5:3], got[2], got[1], got[0],
                        exp[7:6], exp[5:3], exp[2], exp[1], exp[0]);
            end
         end
      end
   end

   initial begin
      bit h_lvl;
      int rst_act;
      model_reset(0);
      model_reset(1);

      // Held in reset, then released
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2);

      // Full count 0..7 then DONE, no reload
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 0);
      idle_cycles(30, 1'b0, 3'd0, 3'd7);

      // Auto-reload 5..7,0..2 then back to 5
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 3'd2, 0);
      idle_cycles(30, 1'b1, 3'd5, 3'd2);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 3'd2, 0);

      // load_val == limit terminates on the first tick; restart from DONE
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 0);
      idle_cycles(5, 1'b0, 3'd4, 3'd4);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3, 0);
      idle_cycles(12, 1'b0, 3'd1, 3'd3);

      // Pause mid-run, resume, then abort while paused
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 0);
      idle_cycles(8, 1'b0, 3'd0, 3'd7);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 0);
      idle_cycles(5, 1'b0, 3'd0, 3'd7);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 0);

      // Start with hold asserted: RUN then PAUSE
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd6, 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd6, 0);
      idle_cycles(4, 1'b0, 3'd3, 3'd6);

      // Asynchronous reset between edges mid-run, then restart
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd7, 0);
      idle_cycles(4, 1'b0, 3'd2, 3'd7);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd7, 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd7, 2);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd7, 0);
      idle_cycles(10, 1'b0, 3'd2, 3'd7);

      // Randomized traffic
      h_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) h_lvl = !h_lvl;
         rst_act = 0;
         if (!rst_n) rst_act = 2;
         else if ($urandom_range(0, 299) == 0) rst_act = 1;
         cycle(($urandom_range(0, 5) == 0), h_lvl, ($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), rst_act);
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q1.size() != 0 || exp_q3.size() != 0) begin
         failures++;
         $display("FAIL drain got pending=%0d/%0d exp 0/0", exp_q1.size(), exp_q3.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
